// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter: FSM state encoding,
// requester port indices and default widths.
package dmem_arb_pkg;

  localparam int DEF_ADDR_W       = 32;
  localparam int DEF_DATA_W       = 32;
  localparam int DEF_MEM_DEPTH    = 4;
  localparam int DEF_READ_LATENCY = 1;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic logic other_port(input logic port);
    return (port == PORT_CPU) ? PORT_DBG : PORT_CPU;
  endfunction

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Two-input round-robin grant. The pointer names the port that wins a tie and
// moves to the loser of each accepted arbitration.
module rr_arb2
  import dmem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant
);

  logic       r_ptr;
  logic [1:0] w_grant;

  // One-hot grant from the request pair and the tie-break pointer
  always_comb begin
    w_grant = 2'b00;
    case (req)
      2'b01:   w_grant = 2'b01;
      2'b10:   w_grant = 2'b10;
      2'b11: begin
        if (r_ptr == PORT_DBG) begin
          w_grant = 2'b10;
        end else begin
          w_grant = 2'b01;
        end
      end
      default: w_grant = 2'b00;
    endcase
  end

  assign grant = w_grant;

  // Pointer update: only an accepted grant moves it, to the non-winning port
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ptr <= PORT_CPU;
    end else if (accept) begin
      r_ptr <= other_port(w_grant[1]);
    end else begin
      r_ptr <= r_ptr;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbiter and sequencer placing the CPU and debug/loader requesters onto the
// single-port data memory, with fixed-latency read-data return.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int MEM_DEPTH    = DEF_MEM_DEPTH,
  parameter int READ_LATENCY = DEF_READ_LATENCY
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  input  logic              req0_write,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  output logic              req0_rvalid,
  output logic [DATA_W-1:0] req0_rdata,
  input  logic              req1_valid,
  input  logic              req1_write,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              req1_rvalid,
  output logic [DATA_W-1:0] req1_rdata,
  output logic              memRead,
  output logic              memWrite,
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] dataIn,
  input  logic [DATA_W-1:0] memDataOut
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(MEM_DEPTH);
  localparam logic [2:0]        LAT_C   = 3'(READ_LATENCY);

  state_t      r_state;
  logic        r_win;
  logic        r_write;
  logic        r_in_range;
  logic [2:0]  r_cnt;

  logic [1:0]        w_req;
  logic [1:0]        w_grant;
  logic              w_accept;
  logic              w_sel_write;
  logic [ADDR_W-1:0] w_sel_addr;
  logic [DATA_W-1:0] w_sel_wdata;
  logic              w_sel_in_range;

  assign w_req    = {req1_valid, req0_valid};
  assign w_accept = (r_state == IDLE) && (w_req != 2'b00) && !reset;

  rr_arb2 u_rr_arb2 (
    .clk    (clk),
    .reset  (reset),
    .req    (w_req),
    .accept (w_accept),
    .grant  (w_grant)
  );

  // The ready pulse must coincide with the accept cycle, so it stays combinational
  assign req0_ready = w_accept && w_grant[0];
  assign req1_ready = w_accept && w_grant[1];

  assign w_sel_write    = w_grant[1] ? req1_write : req0_write;
  assign w_sel_addr     = w_grant[1] ? req1_addr  : req0_addr;
  assign w_sel_wdata    = w_grant[1] ? req1_wdata : req0_wdata;
  assign w_sel_in_range = (w_sel_addr < DEPTH_A);

  // Sequencer FSM; strobes are registered so they are high only during ISSUE
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_win       <= PORT_CPU;
      r_write     <= 1'b0;
      r_in_range  <= 1'b0;
      r_cnt       <= 3'd0;
      memRead     <= 1'b0;
      memWrite    <= 1'b0;
      address     <= {ADDR_W{1'b0}};
      dataIn      <= {DATA_W{1'b0}};
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      req0_rdata  <= {DATA_W{1'b0}};
      req1_rdata  <= {DATA_W{1'b0}};
    end else begin
      memRead     <= 1'b0;
      memWrite    <= 1'b0;
      req0_rvalid <= 1'b0;
      req1_rvalid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_win      <= w_grant[1];
            r_write    <= w_sel_write;
            r_in_range <= w_sel_in_range;
            address    <= w_sel_addr;
            dataIn     <= w_sel_wdata;
            memWrite   <= w_sel_in_range && w_sel_write;
            memRead    <= w_sel_in_range && !w_sel_write;
            r_state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (r_write) begin
            r_state <= IDLE;
          end else begin
            r_cnt   <= LAT_C;
            r_state <= WAIT;
          end
        end
        WAIT: begin
          if (r_cnt == 3'd1) begin
            // Out-of-range reads return zero rather than whatever the memory drives
            if (r_win == PORT_DBG) begin
              req1_rdata  <= r_in_range ? memDataOut : {DATA_W{1'b0}};
              req1_rvalid <= 1'b1;
            end else begin
              req0_rdata  <= r_in_range ? memDataOut : {DATA_W{1'b0}};
              req0_rvalid <= 1'b1;
            end
            r_state <= RESP;
          end else begin
            r_cnt <= r_cnt - 3'd1;
          end
        end
        RESP: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a 4-word memory model.
module tb_dmem_arbiter;

  localparam int RL = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0_valid, req0_write, req1_valid, req1_write;
  logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req0_rvalid, req1_ready, req1_rvalid;
  logic [31:0] req0_rdata, req1_rdata;
  logic        memRead, memWrite;
  logic [31:0] address, dataIn, memDataOut;

  logic [31:0] mem [0:3];

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(
    .ADDR_W(32), .DATA_W(32), .MEM_DEPTH(4), .READ_LATENCY(RL)
  ) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .req0_rvalid(req0_rvalid),
    .req0_rdata(req0_rdata),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .req1_rvalid(req1_rvalid),
    .req1_rdata(req1_rdata),
    .memRead(memRead), .memWrite(memWrite), .address(address), .dataIn(dataIn),
    .memDataOut(memDataOut)
  );

  // Memory model: out-of-range reads drive a poison value the arbiter must not return
  always @(posedge clk) begin
    if (memWrite && address < 32'd4) mem[address[1:0]] <= dataIn;
  end
  assign memDataOut = (address < 32'd4) ? mem[address[1:0]] : 32'hBAD0_BAD0;

  typedef struct {
    logic        port;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic any_out();
    return |{req0_ready, req1_ready, req0_rvalid, req1_rvalid, memRead, memWrite,
             req0_rdata, req1_rdata, address, dataIn};
  endfunction

  function automatic logic rdy(input logic p);
    return p ? req1_ready : req0_ready;
  endfunction

  function automatic logic rv(input logic p);
    return p ? req1_rvalid : req0_rvalid;
  endfunction

  function automatic logic [31:0] rd(input logic p);
    return p ? req1_rdata : req0_rdata;
  endfunction

  task automatic set_req(input logic p, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    if (p) begin
      req1_valid = v; req1_write = w; req1_addr = a; req1_wdata = d;
    end else begin
      req0_valid = v; req0_write = w; req0_addr = a; req0_wdata = d;
    end
  endtask

  task automatic do_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
  endtask

  // One transaction from an idle arbiter, checking every cycle of its timing
  task automatic do_txn(input logic p, input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [31:0] exp_rd);
    logic [1:0] exp_strb;
    int         waits;
    exp_strb = (a < 32'd4) ? (w ? 2'b01 : 2'b10) : 2'b00;
    set_req(p, 1'b1, w, a, d);
    #1;
    waits = 0;
    while (!rdy(p) && waits < 20) begin
      @(posedge clk);
      #2;
      waits++;
    end
    chk("txn_ready_wait", 64'(waits), 64'd0);
    if (!rdy(p)) begin
      set_req(p, 1'b0, w, a, d);
      return;
    end
    tick;
    set_req(p, 1'b0, w, a, d);
    chk("txn_strobe", {62'd0, memRead, memWrite}, {62'd0, exp_strb});
    chk("txn_addr", {32'd0, address}, {32'd0, a});
    if (w) begin
      chk("txn_datain", {32'd0, dataIn}, {32'd0, d});
      tick;
    end else begin
      for (int i = 0; i < RL; i++) begin
        tick;
        chk("txn_early_rvalid", {63'd0, rv(p)}, 64'd0);
      end
      tick;
      chk("txn_rvalid", {62'd0, rv(p), rv(!p)}, 64'd2);
      chk("txn_rdata", {32'd0, rd(p)}, {32'd0, exp_rd});
      tick;
      chk("txn_rvalid_len", {63'd0, rv(p)}, 64'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [13];
    int   n, last, cycles;
    logic g;

    tbl[0]  = '{1'b0, 1'b1, 32'd2, 32'h0000_1111, 32'h0};
    tbl[1]  = '{1'b0, 1'b0, 32'd2, 32'h0,         32'h0000_1111};
    tbl[2]  = '{1'b1, 1'b1, 32'd3, 32'h0000_A5A5, 32'h0};
    tbl[3]  = '{1'b1, 1'b0, 32'd3, 32'h0,         32'h0000_A5A5};
    tbl[4]  = '{1'b1, 1'b1, 32'd0, 32'h0000_00AA, 32'h0};
    tbl[5]  = '{1'b0, 1'b1, 32'd1, 32'h0000_0101, 32'h0};
    tbl[6]  = '{1'b1, 1'b1, 32'd9, 32'h0000_DEAD, 32'h0};
    tbl[7]  = '{1'b0, 1'b0, 32'd1, 32'h0,         32'h0000_0101};
    tbl[8]  = '{1'b0, 1'b0, 32'd9, 32'h0,         32'h0};
    tbl[9]  = '{1'b1, 1'b0, 32'd4, 32'h0,         32'h0};
    tbl[10] = '{1'b0, 1'b0, 32'd3, 32'h0,         32'h0000_A5A5};
    tbl[11] = '{1'b1, 1'b0, 32'd2, 32'h0,         32'h0000_1111};
    tbl[12] = '{1'b0, 1'b0, 32'd0, 32'h0,         32'h0000_00AA};

    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    reset = 1'b1;
    tick;
    tick;
    chk("reset_outputs", {63'd0, any_out()}, 64'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick;
      chk("idle_outputs", {63'd0, any_out()}, 64'd0);
    end

    for (int i = 0; i < 13; i++) begin
      do_txn(tbl[i].port, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
    end

    // Simultaneous requests after reset: port 0 first, port 1 on the next IDLE
    do_reset;
    set_req(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b1, 1'b1, 32'd1, 32'h0000_F0F0);
    #1;
    chk("arb_first_grant", {62'd0, req0_ready, req1_ready}, 64'd2);
    tick;
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("arb_first_strobe", {62'd0, memRead, memWrite}, 64'd2);
    chk("arb_first_addr", {32'd0, address}, 64'd0);
    tick;
    chk("arb_busy_wait", {63'd0, req1_ready}, 64'd0);
    tick;
    chk("arb_resp_rvalid", {62'd0, req0_rvalid, req1_ready}, 64'd2);
    chk("arb_resp_rdata", {32'd0, req0_rdata}, 64'h0000_00AA);
    tick;
    chk("arb_second_grant", {62'd0, req0_ready, req1_ready}, 64'd1);
    tick;
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("arb_second_strobe", {62'd0, memRead, memWrite}, 64'd1);
    chk("arb_second_addr", {32'd0, address}, 64'd1);
    chk("arb_second_data", {32'd0, dataIn}, 64'h0000_F0F0);
    tick;
    do_txn(1'b0, 1'b0, 32'd1, 32'd0, 32'h0000_F0F0);

    // Both ports stream writes: grants alternate 0,1,... every two cycles
    do_reset;
    set_req(1'b0, 1'b1, 1'b1, 32'd0, 32'h0000_0100);
    set_req(1'b1, 1'b1, 1'b1, 32'd2, 32'h0000_0200);
    #1;
    n = 0;
    last = 0;
    cycles = 0;
    while (n < 10 && cycles < 60) begin
      g = req1_ready;
      if (req0_ready || req1_ready) begin
        chk("rr_onehot", {63'd0, req0_ready & req1_ready}, 64'd0);
        chk("rr_grant", {63'd0, g}, {63'd0, n[0]});
        if (n > 0) chk("rr_gap", 64'(cycles - last), 64'd2);
        last = cycles;
        n++;
        tick;
        chk("rr_strobe", {62'd0, memRead, memWrite}, 64'd1);
        if (g) req1_wdata = req1_wdata + 32'd1;
        else   req0_wdata = req0_wdata + 32'd1;
      end else begin
        tick;
      end
      #1;
      cycles++;
    end
    chk("rr_count", 64'(n), 64'd10);
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    tick;

    // Reset while a port 1 load sits in WAIT aborts it
    set_req(1'b1, 1'b1, 1'b0, 32'd3, 32'd0);
    #1;
    chk("abort_ready", {63'd0, req1_ready}, 64'd1);
    tick;
    set_req(1'b1, 1'b0, 1'b0, 32'd3, 32'd0);
    tick;
    chk("abort_wait_addr", {32'd0, address}, 64'd3);
    reset = 1'b1;
    tick;
    chk("abort_outputs", {63'd0, any_out()}, 64'd0);
    reset = 1'b0;
    tick;
    chk("abort_no_rvalid", {62'd0, req0_rvalid, req1_rvalid}, 64'd0);

    // Pointer returns to port 0 after reset even when it pointed at port 1
    do_txn(1'b0, 1'b1, 32'd0, 32'h0000_0055, 32'd0);
    set_req(1'b0, 1'b1, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b1, 1'b0, 32'd3, 32'd0);
    reset = 1'b1;
    #1;
    chk("reset_ready_masked", {62'd0, req0_ready, req1_ready}, 64'd0);
    tick;
    reset = 1'b0;
    #1;
    chk("ptr_after_reset", {62'd0, req0_ready, req1_ready}, 64'd2);
    set_req(1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
    tick;
    tick;
    do_txn(1'b1, 1'b0, 32'd3, 32'd0, 32'h0000_A5A5);
    do_txn(1'b0, 1'b0, 32'd0, 32'd0, 32'h0000_0055);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
